// File: rtl/window_gen_3x3.sv
// Purpose : slides a 3x3 window over a raster pixel stream (valid windows only, no padding).
// Latency : 1 cycle from accepting pixel (r,c), r>=2 and c>=2, to out_valid for window (r-2..r, c-2..c).
// Backpr. : one output register; in_ready = !out_valid || out_ready, and in_ready is also held low in LAST unless sof.
// Ports   : clk/rst_n (async active-low); sof/in_pixel/in_valid/in_ready pixel input;
//           out_window/out_valid/out_ready window output (slot k=row*3+col at [k*W +: W]);
//           frame_done pulses in the cycle the final window of a frame is accepted.
// Option  : WINDOW_GEN_STATS_EN adds win_count[31:0], which counts accepted windows.
//           Reset clears it, as does an accepted sof.
module window_gen_3x3 #(
  parameter int IMAGE_WIDTH = 8,
  parameter int IMG_COLS    = 64,
  parameter int IMG_ROWS    = 64,
  parameter int MATRIX_SIZE = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sof,
  input  logic [IMAGE_WIDTH-1:0]   in_pixel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [IMAGE_WIDTH*9-1:0] out_window,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     frame_done
`ifdef WINDOW_GEN_STATS_EN
  ,
  output logic [31:0]              win_count
`endif
);

  localparam int CW = $clog2(IMG_COLS);
  localparam int RW = $clog2(IMG_ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_ROWS - 1);

  if (MATRIX_SIZE != 3) begin : g_bad_matrix
    $error("window_gen_3x3: MATRIX_SIZE must be 3");
  end
  if (IMG_COLS < 3 || IMG_COLS > 1024 || IMG_ROWS < 3 || IMG_ROWS > 1024) begin : g_bad_dims
    $error("window_gen_3x3: IMG_COLS/IMG_ROWS must be in 3..1024");
  end

  typedef enum logic [1:0] {FILL, RUN, LAST} state_t;
  typedef logic [2:0][IMAGE_WIDTH-1:0] col_t;  // index 0 = top (oldest row)

  state_t                   state_q, state_d;
  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic                     out_valid_q, out_valid_d;
  logic [IMAGE_WIDTH*9-1:0] out_window_q, out_window_d;
  // Column shift register: the two previous columns are held; the third
  // (newest) column is formed from the line buffers and the incoming pixel.
  col_t                     sh_c1_q, sh_c1_d;
  col_t                     sh_c2_q, sh_c2_d;
`ifdef WINDOW_GEN_STATS_EN
  logic [31:0]              win_count_q, win_count_d;
`endif

  // Line buffers: lb1 holds row r-1, lb2 holds row r-2.
  logic [IMAGE_WIDTH-1:0]   lb1_q [IMG_COLS];
  logic [IMAGE_WIDTH-1:0]   lb2_q [IMG_COLS];

  logic          pix_acc, win_acc;
  logic [CW-1:0] eff_col;
  logic [RW-1:0] eff_row;
  col_t          new_col;

  // An accepted sof overrides the counters so that pixel lands at (0,0).
  assign eff_col  = sof ? '0 : col_q;
  assign eff_row  = sof ? '0 : row_q;
  assign new_col  = {in_pixel, lb1_q[eff_col], lb2_q[eff_col]};

  assign in_ready = (!out_valid_q || out_ready) && ((state_q != LAST) || sof);
  assign pix_acc  = in_valid && in_ready;
  assign win_acc  = out_valid_q && out_ready;

  assign out_valid  = out_valid_q;
  assign out_window = out_window_q;
  assign frame_done = (state_q == LAST) && win_acc;
`ifdef WINDOW_GEN_STATS_EN
  assign win_count  = win_count_q;
`endif

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    out_valid_d  = out_valid_q;
    out_window_d = out_window_q;
    sh_c1_d      = sh_c1_q;
    sh_c2_d      = sh_c2_q;
`ifdef WINDOW_GEN_STATS_EN
    win_count_d  = win_count_q;
    if (win_acc) win_count_d = win_count_q + 32'd1;
    if (pix_acc && sof) win_count_d = '0;
`endif

    if (win_acc) out_valid_d = 1'b0;

    // The final window has left: the row counter wraps here and only here.
    if ((state_q == LAST) && win_acc) begin
      state_d = FILL;
      row_d   = '0;
      col_d   = '0;
    end

    if (pix_acc) begin
      sh_c1_d = sh_c2_q;
      sh_c2_d = new_col;
      if (sof) state_d = FILL;

      if (eff_col == COL_LAST) begin
        col_d = '0;
        // The last row does not advance; LAST exit resets the row.
        row_d = (eff_row == ROW_LAST) ? eff_row : eff_row + RW'(1);
        if (eff_row == RW'(1)) state_d = RUN;
        if (eff_row == ROW_LAST) state_d = LAST;
      end else begin
        col_d = eff_col + CW'(1);
        row_d = eff_row;
      end

      // Column c<2 still has stale columns from the previous row in the shift
      // register, so gating on c>=2 keeps windows from spanning a row wrap.
      if ((eff_row >= RW'(2)) && (eff_col >= CW'(2))) begin
        out_valid_d = 1'b1;
        for (int rr = 0; rr < 3; rr++) begin
          out_window_d[(rr*3 + 0)*IMAGE_WIDTH +: IMAGE_WIDTH] = sh_c1_q[rr];
          out_window_d[(rr*3 + 1)*IMAGE_WIDTH +: IMAGE_WIDTH] = sh_c2_q[rr];
          out_window_d[(rr*3 + 2)*IMAGE_WIDTH +: IMAGE_WIDTH] = new_col[rr];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      out_window_q <= '0;
      sh_c1_q      <= '0;
      sh_c2_q      <= '0;
`ifdef WINDOW_GEN_STATS_EN
      win_count_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      out_window_q <= out_window_d;
      sh_c1_q      <= sh_c1_d;
      sh_c2_q      <= sh_c2_d;
`ifdef WINDOW_GEN_STATS_EN
      win_count_q  <= win_count_d;
`endif
    end
  end

  // Line buffer storage carries no reset; rows 0 and 1 of every frame
  // overwrite it before any window reads it.
  always_ff @(posedge clk) begin
    if (pix_acc) begin
      lb1_q[eff_col] <= in_pixel;
      lb2_q[eff_col] <= lb1_q[eff_col];
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
module tb_window_gen_3x3;

  localparam int W    = 8;
  localparam int COLS = 4;
  localparam int ROWS = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           sof;
  logic [W-1:0]   in_pixel;
  logic           in_valid;
  logic           in_ready;
  logic [W*9-1:0] out_window;
  logic           out_valid;
  logic           out_ready;
  logic           frame_done;
`ifdef WINDOW_GEN_STATS_EN
  logic [31:0]    win_count;
`endif

  window_gen_3x3 #(
    .IMAGE_WIDTH(W), .IMG_COLS(COLS), .IMG_ROWS(ROWS), .MATRIX_SIZE(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sof(sof), .in_pixel(in_pixel),
    .in_valid(in_valid), .in_ready(in_ready), .out_window(out_window),
    .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done)
`ifdef WINDOW_GEN_STATS_EN
    , .win_count(win_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W*9-1:0] win;
    logic           last;
  } exp_t;

  exp_t           sb[$];
  int             n_checks = 0;
  int             n_fail   = 0;
  int             win_rx   = 0;
  int             fd_cnt   = 0;
  logic           stall_prev = 1'b0;
  logic [W*9-1:0] prev_win = '0;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pix(input int f, input int r, input int c);
    return W'(f*16 + r*COLS + c);
  endfunction

  // Reference window built straight from the image coordinates.
  function automatic logic [W*9-1:0] exp_win(input int f, input int r, input int c);
    logic [W*9-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*W +: W] = pix(f, r - 2 + k/3, c - 2 + k%3);
    return w;
  endfunction

  // Output monitor / scoreboard consumer, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        check_eq("hold_vld", 72'(out_valid), 72'd1);
        check_eq("hold_win", 72'(out_window), 72'(prev_win));
      end
      if (out_valid && out_ready) begin
        win_rx++;
        if (sb.size() == 0) begin
          check_eq("spurious_win", 72'(out_valid), 72'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("win", 72'(out_window), 72'(e.win));
          check_eq("frame_done", 72'(frame_done), 72'(e.last));
        end
      end
      if (frame_done) fd_cnt++;
      stall_prev = out_valid && !out_ready;
      prev_win   = out_window;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send_pixel(input logic [W-1:0] p, input logic s);
    logic ok;
    #1;
    in_valid = 1'b1;
    in_pixel = p;
    sof      = s;
    ok       = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      if (ok) break;
    end
    if (!ok) check_eq("in_ready_timeout", 72'(in_ready), 72'd1);
  endtask

  task automatic send_frame(input int f, input logic with_sof, input int first, input int last_idx,
                            input logic lat_chk);
    for (int idx = first; idx <= last_idx; idx++) begin
      int r, c;
      r = idx / COLS;
      c = idx % COLS;
      if (r >= 2 && c >= 2) begin
        exp_t e;
        e.win  = exp_win(f, r, c);
        e.last = (r == ROWS - 1) && (c == COLS - 1);
        sb.push_back(e);
      end
      send_pixel(pix(f, r, c), with_sof && (idx == 0));
      if (lat_chk && idx == 2*COLS + 1) begin
        #1 check_eq("lat_no_vld", 72'(out_valid), 72'd0);
      end
      if (lat_chk && idx == 2*COLS + 2) begin
        #1 check_eq("lat_vld", 72'(out_valid), 72'd1);
      end
    end
  endtask

  task automatic idle(input int n);
    #1;
    in_valid = 1'b0;
    sof      = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int base_w, base_fd;
    rst_n     = 1'b0;
    sof       = 1'b0;
    in_pixel  = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 72'(out_valid), 72'd0);
    check_eq("rst_out_window", 72'(out_window), 72'd0);
    check_eq("rst_frame_done", 72'(frame_done), 72'd0);
    check_eq("rst_in_ready", 72'(in_ready), 72'd1);
    rst_n = 1'b1;
    #1 check_eq("rel_in_ready", 72'(in_ready), 72'd1);
    @(posedge clk);

    // Basic frame, continuous flow, latency check around pixel 10
    base_w = win_rx; base_fd = fd_cnt;
    send_frame(0, 1'b1, 0, COLS*ROWS - 1, 1'b1);
    idle(6);
    check_eq("f0_wins", 72'(win_rx - base_w), 72'd4);
    check_eq("f0_fdone", 72'(fd_cnt - base_fd), 72'd1);

    // Backpressure at the first window for 5 cycles
    base_w = win_rx;
    fork
      send_frame(1, 1'b1, 0, COLS*ROWS - 1, 1'b0);
      begin
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
          @(posedge clk);
          #1;
          if (out_valid) begin seen = 1'b1; break; end
        end
        if (!seen) check_eq("stall_wait_vld", 72'(out_valid), 72'd1);
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check_eq("stall_in_ready", 72'(in_ready), 72'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(6);
    check_eq("f1_wins", 72'(win_rx - base_w), 72'd4);

    // sof re-asserted at pixel 6 abandons the partial frame
    base_w = win_rx;
    send_frame(2, 1'b1, 0, 5, 1'b0);
    send_frame(3, 1'b1, 0, COLS*ROWS - 1, 1'b0);
    idle(6);
    check_eq("sof_restart_wins", 72'(win_rx - base_w), 72'd4);
`ifdef WINDOW_GEN_STATS_EN
    check_eq("sof_restart_cnt", 72'(win_count), 72'd4);
`endif

    // Reset pulsed at pixel 9; next frame starts without sof
    send_frame(4, 1'b1, 0, 8, 1'b0);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("midrst_out_valid", 72'(out_valid), 72'd0);
    check_eq("midrst_in_ready", 72'(in_ready), 72'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    base_w = win_rx;
    send_frame(5, 1'b0, 0, COLS*ROWS - 1, 1'b0);
    idle(6);
    check_eq("postrst_wins", 72'(win_rx - base_w), 72'd4);

    // Two frames; LAST blocks a non-sof pixel; frame_done twice
    base_fd = fd_cnt;
    send_frame(6, 1'b1, 0, COLS*ROWS - 1, 1'b0);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pixel  = 8'h77;
    sof       = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("last_stall_in_ready", 72'(in_ready), 72'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check_eq("last_nosof_in_ready", 72'(in_ready), 72'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check_eq("after_last_in_ready", 72'(in_ready), 72'd1);
    idle(3);
`ifdef WINDOW_GEN_STATS_EN
    check_eq("cnt_frame1", 72'(win_count), 72'd4);
`endif
    send_frame(7, 1'b1, 0, 0, 1'b0);
`ifdef WINDOW_GEN_STATS_EN
    #1 check_eq("cnt_cleared", 72'(win_count), 72'd0);
`endif
    send_frame(7, 1'b1, 1, COLS*ROWS - 1, 1'b0);
    idle(6);
`ifdef WINDOW_GEN_STATS_EN
    check_eq("cnt_frame2", 72'(win_count), 72'd4);
`endif
    check_eq("two_frame_fdone", 72'(fd_cnt - base_fd), 72'd2);
    check_eq("sb_drained", 72'(sb.size()), 72'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
